line_window_buffer: RTL

//  Parametrised successor of the 3-line FIFO line buffer: buffers ROWS-1 image lines and emits a

---
 rtl/line_window_buffer_pkg.sv | 7 +
 rtl/line_window_buffer_line_ram.sv | 25 ++
 rtl/line_window_buffer.sv | 80 ++++++++
 3 files changed

// File: rtl/line_window_buffer_pkg.sv
// line_window_buffer_pkg: default geometry shared by the line window buffer and its line RAMs.
package line_window_buffer_pkg;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_DEPTH   = 640;
  localparam int DEF_ROWS    = 3;
  localparam int DEF_FRAME_H = 480;
endpackage

// File: rtl/line_window_buffer_line_ram.sv
// line_ram: single-port read-first line memory with registered read data.
module line_ram
  import line_window_buffer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  always_ff @(posedge clk)
    if (en_i && we_i) mem_q[addr_i] <= wdata_i;
  always_ff @(posedge clk or negedge rst)
    if (!rst) rdata_q <= '0;
    else if (en_i) rdata_q <= mem_q[addr_i];
  assign rdata_o = rdata_q;
endmodule

// File: rtl/line_window_buffer.sv
// line_window_buffer: buffers ROWS-1 lines and emits a ROWS-tall pixel column per accepted pixel.
// Line RAMs are used round-robin per row; the read side rotates them back into oldest-first order.
module line_window_buffer
  import line_window_buffer_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int ROWS    = DEF_ROWS,
  parameter int FRAME_H = DEF_FRAME_H,
  localparam int CW     = $clog2(DEPTH),
  localparam int RW     = $clog2(FRAME_H)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we_i,
  input  logic                   sof_i,
  input  logic [DATA_W-1:0]      data_i,
  output logic [ROWS*DATA_W-1:0] data_o,
  output logic                   valid_o,
  output logic [CW-1:0]          col_o,
  output logic [RW-1:0]          row_o,
  output logic                   done_o
);
  localparam int L  = ROWS - 1;
  localparam int PW = $clog2(ROWS);
  logic [CW-1:0] col_q, col_d, cur_col, out_col_q;
  logic [RW-1:0] row_q, row_d, cur_row, out_row_q;
  logic [PW-1:0] ptr_q, ptr_d, cur_ptr, sel_q;
  logic [DATA_W-1:0] tap_q;
  logic [L*DATA_W-1:0] rd;
  logic [2*L*DATA_W-1:0] rd2;
  logic valid_q, done_q, eol, eof;
  always_comb begin
    cur_col = sof_i ? '0 : col_q;
    cur_row = sof_i ? '0 : row_q;
    cur_ptr = sof_i ? '0 : ptr_q;
    eol     = cur_col == CW'(DEPTH - 1);
    eof     = eol && cur_row == RW'(FRAME_H - 1);
    col_d   = !we_i ? cur_col : eol ? '0 : cur_col + 1'b1;
    row_d   = !(we_i && eol) ? cur_row : eof ? '0 : cur_row + 1'b1;
    ptr_d   = !(we_i && eol) ? cur_ptr : cur_ptr == PW'(L - 1) ? '0 : cur_ptr + 1'b1;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      col_q     <= '0;
      row_q     <= '0;
      ptr_q     <= '0;
      sel_q     <= '0;
      tap_q     <= '0;
      out_col_q <= '0;
      out_row_q <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      ptr_q   <= ptr_d;
      valid_q <= we_i && cur_row >= RW'(L);
      done_q  <= we_i && eof;
      if (we_i) begin
        sel_q     <= cur_ptr;
        tap_q     <= data_i;
        out_col_q <= cur_col;
        out_row_q <= cur_row;
      end
    end
  for (genvar i = 0; i < L; i++) begin : g_ram
    line_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
      .clk(clk), .rst(rst), .en_i(we_i), .we_i(cur_ptr == PW'(i)),
      .addr_i(cur_col), .wdata_i(data_i), .rdata_o(rd[i*DATA_W +: DATA_W])
    );
  end
  // RAM sel_q was written during the oldest buffered row, so rotating from it gives oldest-first.
  assign rd2     = {rd, rd};
  assign data_o  = {tap_q, rd2[sel_q*DATA_W +: L*DATA_W]};
  assign valid_o = valid_q;
  assign done_o  = done_q;
  assign col_o   = out_col_q;
  assign row_o   = out_row_q;
endmodule
